// File: rtl/execute_stage.sv
// Execute stage: selects operand B, runs the ALU (single-cycle ops plus an
// iterative shift-and-add multiply) and hands registered results downstream
// through a valid/ready handshake. Upstream is stalled while a multiply runs.
module execute_stage #(
  parameter int WIDTH        = 32,
  parameter int OFFSET_SHIFT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] pcOffsetFilled,
  input  logic             aluSRC,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] pcIn,
  input  logic [4:0]       writeRegisterIn,
  input  logic             regWriteIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluResult,
  output logic             zeroFlag,
  output logic [WIDTH-1:0] branchTarget,
  output logic [4:0]       writeRegisterOut,
  output logic             regWriteOut,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {IDLE, MULTIPLY} stateT;

  stateT stateQ, stateD;

  logic [WIDTH-1:0] aShiftQ, aShiftD;
  logic [WIDTH-1:0] bShiftQ, bShiftD;
  logic [WIDTH-1:0] accQ, accD;
  logic [CW-1:0]    countQ, countD;
  logic [WIDTH-1:0] btPendQ, btPendD;
  logic [4:0]       wrPendQ, wrPendD;
  logic             rwPendQ, rwPendD;

  logic             outValidQ, outValidD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic             zeroQ, zeroD;
  logic [WIDTH-1:0] targetQ, targetD;
  logic [4:0]       wrOutQ, wrOutD;
  logic             rwOutQ, rwOutD;

  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] aluOut;
  logic [WIDTH-1:0] mulPartial;
  logic             accept;
  logic             isMulOp;
  logic             mulDone;

  assign operandB   = aluSRC ? pcOffsetFilled : readData2;
  assign target     = pcIn + (pcOffsetFilled << OFFSET_SHIFT);
  assign accept     = inValid && inReady;
  assign isMulOp    = (aluOp == OP_MUL);
  assign mulPartial = bShiftQ[0] ? (accQ + aShiftQ) : accQ;
  assign mulDone    = (stateQ == MULTIPLY) && (countQ == LAST);

  // Single-cycle ALU result; multiply and unused opcodes yield zero here.
  always_comb begin
    aluOut = '0;
    case (aluOp)
      4'd0: aluOut = readData1 + operandB;
      4'd1: aluOut = readData1 - operandB;
      4'd2: aluOut = readData1 & operandB;
      4'd3: aluOut = readData1 | operandB;
      4'd4: aluOut = readData1 ^ operandB;
      4'd5: aluOut = readData1 << operandB[4:0];
      4'd6: aluOut = readData1 >> operandB[4:0];
      4'd7: aluOut = operandB;
      default: aluOut = '0;
    endcase
  end

  // State register for the IDLE/MULTIPLY controller.
  always_ff @(posedge clock) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Next state: enter MULTIPLY on an accepted MUL, leave after the last iteration.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:     if (accept && isMulOp) stateD = MULTIPLY;
      MULTIPLY: if (mulDone) stateD = IDLE;
      default:  stateD = IDLE;
    endcase
  end

  // Controller outputs; inReady is forced low during reset.
  always_comb begin
    inReady = !reset && (stateQ == IDLE) && (!outValidQ || outReady);
    busy    = (stateQ == MULTIPLY);
  end

  // Datapath next values: multiplier iteration and the output register bank.
  always_comb begin
    aShiftD   = aShiftQ;
    bShiftD   = bShiftQ;
    accD      = accQ;
    countD    = countQ;
    btPendD   = btPendQ;
    wrPendD   = wrPendQ;
    rwPendD   = rwPendQ;
    outValidD = outValidQ;
    resultD   = resultQ;
    zeroD     = zeroQ;
    targetD   = targetQ;
    wrOutD    = wrOutQ;
    rwOutD    = rwOutQ;

    if (accept && isMulOp) begin
      aShiftD = readData1;
      bShiftD = operandB;
      accD    = '0;
      countD  = '0;
      btPendD = target;
      wrPendD = writeRegisterIn;
      rwPendD = regWriteIn;
    end else if (stateQ == MULTIPLY) begin
      accD    = mulPartial;
      aShiftD = aShiftQ << 1;
      bShiftD = bShiftQ >> 1;
      countD  = countQ + CW'(1);
    end

    if (accept && !isMulOp) begin
      outValidD = 1'b1;
      resultD   = aluOut;
      zeroD     = (aluOut == '0);
      targetD   = target;
      wrOutD    = writeRegisterIn;
      rwOutD    = regWriteIn;
    end else if (mulDone) begin
      outValidD = 1'b1;
      resultD   = mulPartial;
      zeroD     = (mulPartial == '0);
      targetD   = btPendQ;
      wrOutD    = wrPendQ;
      rwOutD    = rwPendQ;
    end else if (outValidQ && outReady) begin
      outValidD = 1'b0;
    end
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      aShiftQ   <= '0;
      bShiftQ   <= '0;
      accQ      <= '0;
      countQ    <= '0;
      btPendQ   <= '0;
      wrPendQ   <= '0;
      rwPendQ   <= 1'b0;
      outValidQ <= 1'b0;
      resultQ   <= '0;
      zeroQ     <= 1'b0;
      targetQ   <= '0;
      wrOutQ    <= '0;
      rwOutQ    <= 1'b0;
    end else begin
      aShiftQ   <= aShiftD;
      bShiftQ   <= bShiftD;
      accQ      <= accD;
      countQ    <= countD;
      btPendQ   <= btPendD;
      wrPendQ   <= wrPendD;
      rwPendQ   <= rwPendD;
      outValidQ <= outValidD;
      resultQ   <= resultD;
      zeroQ     <= zeroD;
      targetQ   <= targetD;
      wrOutQ    <= wrOutD;
      rwOutQ    <= rwOutD;
    end
  end

  assign outValid         = outValidQ;
  assign aluResult        = resultQ;
  assign zeroFlag         = zeroQ;
  assign branchTarget     = targetQ;
  assign writeRegisterOut = wrOutQ;
  assign regWriteOut      = rwOutQ;

endmodule
